// File: rtl/tt_mux_sel_seq_if.sv
// ----------------------------------------------------------------------------
// tt_mux_sel_seq_if
// Request/status bundle between the management logic and the mux select
// sequencer.
//   req_valid  master->slave  a select request is present
//   req_addr   master->slave  target project address (ADDR_W)
//   req_ena    master->slave  ctrl_ena value to apply once selected
//   req_ready  slave->master  sequencer can accept a request
//   busy       slave->master  sequence in progress
//   done       slave->master  one-cycle pulse: target selected, enable applied
//   cur_addr   slave->master  shadow copy of the mux select counter (ADDR_W)
// ----------------------------------------------------------------------------
interface tt_mux_sel_seq_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ena;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;

    modport master (
        output req_valid,
        output req_addr,
        output req_ena,
        input  req_ready,
        input  busy,
        input  done,
        input  cur_addr
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_ena,
        output req_ready,
        output busy,
        output done,
        output cur_addr
    );
endinterface

// File: rtl/tt_mux_sel_seq.sv
// ----------------------------------------------------------------------------
// tt_mux_sel_seq
// Turns a target project address into the pin waveform the mux's ripple
// select counter needs: drop enable, optionally reset the counter, pulse inc
// N times, then restore enable. A shadow register tracks the counter so that
// forward moves skip the reset.
// Ports:
//   clk             system clock
//   rst             synchronous reset, active-high
//   bus             request/status bundle (slave side)
//   ctrl_sel_rst_n  to mux: select counter async reset, active-low
//   ctrl_sel_inc    to mux: select counter increments on each rising edge
//   ctrl_ena        to mux: enable for the selected project
// ----------------------------------------------------------------------------
module tt_mux_sel_seq #(
    parameter int ADDR_W     = 10,
    parameter int SETTLE_CYC = 2,
    parameter int RST_CYC    = 2,
    parameter int PULSE_CYC  = 1
) (
    input  logic                clk,
    input  logic                rst,
    tt_mux_sel_seq_if.slave     bus,
    output logic                ctrl_sel_rst_n,
    output logic                ctrl_sel_inc,
    output logic                ctrl_ena
);

    localparam int TMR_MAX = (SETTLE_CYC > RST_CYC)
                           ? ((SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC)
                           : ((RST_CYC > PULSE_CYC) ? RST_CYC : PULSE_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    // Timers count down from duration-1; a phase ends in the cycle the timer is 0.
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] RST_LD    = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        OFF,
        RST,
        INC_HI,
        INC_LO,
        DONE
    } state_t;

    state_t              state_reg;
    logic [TMR_W-1:0]    timer_reg;
    logic [ADDR_W-1:0]   n_reg;
    logic [ADDR_W-1:0]   tgt_reg;
    logic                ena_lat_reg;
    logic [ADDR_W-1:0]   cur_addr_reg;
    logic                rst_n_reg;
    logic                inc_reg;
    logic                ena_reg;
    logic                done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Holding rst_n low here forces the mux counter to match cur_addr=0.
            state_reg    <= IDLE;
            timer_reg    <= '0;
            n_reg        <= '0;
            tgt_reg      <= '0;
            ena_lat_reg  <= 1'b0;
            cur_addr_reg <= '0;
            rst_n_reg    <= 1'b0;
            inc_reg      <= 1'b0;
            ena_reg      <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            rst_n_reg <= 1'b1;
            unique case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        tgt_reg     <= bus.req_addr;
                        ena_lat_reg <= bus.req_ena;
                        ena_reg     <= 1'b0;
                        timer_reg   <= SETTLE_LD;
                        state_reg   <= OFF;
                    end
                end
                OFF: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - TMR_W'(1);
                    end else if (tgt_reg < cur_addr_reg) begin
                        // The counter only counts up, so backward moves restart from 0.
                        state_reg    <= RST;
                        timer_reg    <= RST_LD;
                        rst_n_reg    <= 1'b0;
                        cur_addr_reg <= '0;
                        n_reg        <= tgt_reg;
                    end else if (tgt_reg != cur_addr_reg) begin
                        state_reg    <= INC_HI;
                        timer_reg    <= PULSE_LD;
                        inc_reg      <= 1'b1;
                        cur_addr_reg <= cur_addr_reg + ADDR_W'(1);
                        n_reg        <= tgt_reg - cur_addr_reg;
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        ena_reg   <= ena_lat_reg;
                    end
                end
                RST: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - TMR_W'(1);
                        rst_n_reg <= 1'b0;
                    end else if (n_reg != '0) begin
                        state_reg    <= INC_HI;
                        timer_reg    <= PULSE_LD;
                        inc_reg      <= 1'b1;
                        cur_addr_reg <= cur_addr_reg + ADDR_W'(1);
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        ena_reg   <= ena_lat_reg;
                    end
                end
                INC_HI: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - TMR_W'(1);
                    end else begin
                        state_reg <= INC_LO;
                        timer_reg <= PULSE_LD;
                        inc_reg   <= 1'b0;
                        n_reg     <= n_reg - ADDR_W'(1);
                    end
                end
                INC_LO: begin
                    // Full low phase before the next rising edge lets the ripple settle.
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - TMR_W'(1);
                    end else if (n_reg != '0) begin
                        state_reg    <= INC_HI;
                        timer_reg    <= PULSE_LD;
                        inc_reg      <= 1'b1;
                        cur_addr_reg <= cur_addr_reg + ADDR_W'(1);
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        ena_reg   <= ena_lat_reg;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_reg == IDLE) && !rst;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.cur_addr    = cur_addr_reg;
    assign ctrl_sel_rst_n  = rst_n_reg;
    assign ctrl_sel_inc    = inc_reg;
    assign ctrl_ena        = ena_reg;

endmodule

// File: tb/tb_tt_mux_sel_seq.sv
// ----------------------------------------------------------------------------
// tb_tt_mux_sel_seq
// Drives select requests into tt_mux_sel_seq and watches the mux pins through
// a model of the ripple select counter (cleared while rst_n is low, +1 on each
// inc rising edge). Expected latency, pulse count and reset use come from the
// move rules: backward moves reset, forward moves pulse the difference.
// ----------------------------------------------------------------------------
module tb_tt_mux_sel_seq;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_n;
    logic inc;
    logic ena;

    tt_mux_sel_seq_if #(.ADDR_W(AW)) bus ();

    tt_mux_sel_seq #(
        .ADDR_W     (AW),
        .SETTLE_CYC (2),
        .RST_CYC    (2),
        .PULSE_CYC  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .ctrl_sel_rst_n (rst_n),
        .ctrl_sel_inc   (inc),
        .ctrl_ena       (ena)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int ena;
        int lat;
        int edges;
        int rlow;
    } vec_t;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   model_cnt = 0;   // ripple counter model
    int   ref_cur   = 0;   // where the bench believes the counter sits
    logic prev_inc  = 1'b0;
    int   edge_seen = 0;
    int   low_seen  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called once per cycle at the negedge.
    task automatic sample();
        edge_seen = 0;
        low_seen  = 0;
        if (!rst_n) begin
            model_cnt = 0;
            low_seen  = 1;
        end else if (inc && !prev_inc) begin
            model_cnt = (model_cnt + 1) % (1 << AW);
            edge_seen = 1;
        end
        prev_inc = inc;
    endtask

    task automatic run_req(input int addr, input int ena_v, input int lat, input int edges,
                           input int rlow, input int poke, input string name);
        int w;
        int k;
        int n_edge;
        int n_low;
        int viol;
        int got;
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(addr);
        bus.req_ena   = (ena_v != 0);
        w = 0;
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            sample();
            w++;
        end
        chk({name, ".ready"}, int'(bus.req_ready), 1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 1; n_edge = 0; n_low = 0; viol = 0; got = 0;
        while (k < 5000 && got == 0) begin
            sample();
            n_edge += edge_seen;
            n_low  += low_seen;
            if (ena && (!rst_n || inc)) viol++;
            if (k == 1) begin
                chk({name, ".ena_off"}, int'(ena), 0);
                chk({name, ".busy"}, int'(bus.busy), 1);
            end
            if (poke > 0 && k == poke) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = AW'(7);
                chk({name, ".ready_busy"}, int'(bus.req_ready), 0);
            end
            if (poke > 0 && k == poke + 1) bus.req_valid = 1'b0;
            if (bus.done) begin
                got = k;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk({name, ".latency"}, got, lat);
        chk({name, ".inc_edges"}, n_edge, edges);
        chk({name, ".rst_low"}, n_low, rlow);
        chk({name, ".ena_unsafe"}, viol, 0);
        chk({name, ".cur_addr"}, int'(bus.cur_addr), addr);
        chk({name, ".model_cnt"}, model_cnt, addr);
        chk({name, ".ena_final"}, int'(ena), ena_v);
        @(negedge clk);
        sample();
        chk({name, ".done_once"}, int'(bus.done), 0);
        chk({name, ".idle"}, int'(bus.busy), 0);
        ref_cur = addr;
        $display("req %-10s addr=%0d ena=%0d latency=%0d edges=%0d rst_low=%0d", name, addr, ena_v,
                 got, n_edge, n_low);
    endtask

    // Expectations derived from the move rules and the bench's own position.
    task automatic run_model(input int addr, input int ena_v, input int poke, input string name);
        int  edges;
        int  rlow;
        bit  back;
        back  = (addr < ref_cur);
        edges = back ? addr : addr - ref_cur;
        rlow  = back ? 2 : 0;
        run_req(addr, ena_v, 2 + rlow + 2 * edges + 1, edges, rlow, poke, name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[5];

    initial begin
        int w;
        int dones;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_ena   = 1'b0;

        tbl[0] = '{addr: 3, ena: 1, lat: 9, edges: 3, rlow: 0};
        tbl[1] = '{addr: 5, ena: 1, lat: 7, edges: 2, rlow: 0};
        tbl[2] = '{addr: 1, ena: 1, lat: 7, edges: 1, rlow: 2};
        tbl[3] = '{addr: 1, ena: 0, lat: 3, edges: 0, rlow: 0};
        tbl[4] = '{addr: 0, ena: 1, lat: 5, edges: 0, rlow: 2};

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        sample();
        chk("rst.rst_n", int'(rst_n), 0);
        chk("rst.inc", int'(inc), 0);
        chk("rst.ena", int'(ena), 0);
        chk("rst.cur_addr", int'(bus.cur_addr), 0);
        chk("rst.ready", int'(bus.req_ready), 0);
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);
        sample();
        chk("rel.ready", int'(bus.req_ready), 1);
        chk("rel.rst_n", int'(rst_n), 1);
        chk("rel.model", model_cnt, 0);
        $display("reset released ready=%0d rst_n=%0d", bus.req_ready, rst_n);

        for (int i = 0; i < 5; i++) begin
            run_req(tbl[i].addr, tbl[i].ena, tbl[i].lat, tbl[i].edges, tbl[i].rlow, 0,
                    $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            run_model(int'($urandom_range(0, 40)), int'($urandom_range(0, 1)), 0,
                      $sformatf("rnd%0d", i));
        end

        // Full-range forward move with a stray request while busy.
        run_model(0, 0, 0, "to_zero");
        run_model(1023, 1, 10, "far");
        run_model(0, 0, 0, "back_zero");

        // Reset in the middle of a long forward move.
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(600);
        bus.req_ena   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        w = 0;
        sample();
        while (!(bus.cur_addr == AW'(500) && !inc && bus.busy) && w < 3000) begin
            @(negedge clk);
            sample();
            w++;
        end
        chk("midrst.reach500", int'(bus.cur_addr), 500);
        chk("midrst.model500", model_cnt, 500);
        rst = 1'b1;
        @(negedge clk);
        sample();
        rst = 1'b0;
        chk("midrst.rst_n", int'(rst_n), 0);
        chk("midrst.inc", int'(inc), 0);
        chk("midrst.ena", int'(ena), 0);
        chk("midrst.cur_addr", int'(bus.cur_addr), 0);
        chk("midrst.busy", int'(bus.busy), 0);
        chk("midrst.model", model_cnt, 0);
        dones = int'(bus.done);
        repeat (4) begin
            @(negedge clk);
            sample();
            dones += int'(bus.done);
        end
        chk("midrst.no_done", dones, 0);
        chk("midrst.ready", int'(bus.req_ready), 1);
        $display("mid-sequence reset cur_addr=%0d model=%0d dones=%0d", bus.cur_addr, model_cnt,
                 dones);
        ref_cur = 0;
        run_model(2, 1, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
